// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register carrying payload, PC, write-enable and write-register.
// Latency 1 cycle; flush has priority over everything. Build with SKID_BUFFER_EN for a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned WR_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic              in_wen,
    input  logic [WR_W-1:0]   in_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc8,
    output logic              out_wen,
    output logic [WR_W-1:0]   out_wr
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       pc;
        logic              wen;
        logic [WR_W-1:0]   wr;
    } entry_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef SKID_BUFFER_EN
    localparam logic [1:0] ST_TWO   = 2'd2;
`endif

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     in_entry;
    logic       in_fire;
    logic       out_fire;

    assign in_entry = '{data: in_data, pc: in_pc, wen: in_wen, wr: in_wr};
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q.data;
    assign out_pc    = head_q.pc;
    assign out_pc8   = head_q.pc + 32'd8;
    assign out_wen   = head_q.wen & out_valid;
    assign out_wr    = head_q.wr;

`ifdef SKID_BUFFER_EN
    entry_t skid_q, skid_d;
    logic   rdy_q, rdy_d;

    // in_ready comes straight from a flop so no ready path crosses the stage.
    assign in_ready = rdy_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = '{data: '0, pc: flush_pc, wen: 1'b0, wr: '0};
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = in_entry;
                    end else if (in_fire) begin
                        skid_d  = in_entry;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        rdy_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '{data: '0, pc: RESET_PC, wen: 1'b0, wr: '0};
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end
`else
    // Single entry: accept whenever the head is empty or leaving this cycle.
    assign in_ready = !out_valid | out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = '{data: '0, pc: flush_pc, wen: 1'b0, wr: '0};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        head_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire) begin
                        head_d = in_entry;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            head_q  <= '{data: '0, pc: RESET_PC, wen: 1'b0, wr: '0};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors, expected entries queued at acceptance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_pc;
    logic        in_wen;
    logic [4:0]  in_wr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_pc;
    logic [31:0] out_pc8;
    logic        out_wen;
    logic [4:0]  out_wr;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .in_wen(in_wen), .in_wr(in_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
        .out_pc8(out_pc8), .out_wen(out_wen), .out_wr(out_wr)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        wen;
        logic [4:0]  wr;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int waits  = 0;
    bit drv_done;

`ifdef SKID_BUFFER_EN
    localparam int HELD = 2;
`else
    localparam int HELD = 1;
`endif

    // Hand-computed vectors: pc8 is written out, including the wrap cases.
    logic [31:0] vd  [8] = '{32'h1111_1111, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h0000_0000,
                             32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0001, 32'hCAFE_F00D};
    logic [31:0] vpc [8] = '{32'h0000_3000, 32'h0000_3004, 32'h7FFF_FFF8, 32'hFFFF_FFFC,
                             32'hFFFF_FFF8, 32'h0040_0000, 32'h0000_FFFC, 32'h0000_3010};
    logic [31:0] vp8 [8] = '{32'h0000_3008, 32'h0000_300C, 32'h8000_0000, 32'h0000_0004,
                             32'h0000_0000, 32'h0040_0008, 32'h0001_0004, 32'h0000_3018};
    logic        vwen[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0]  vwr [8] = '{5'd1, 5'd2, 5'd31, 5'd5, 5'd0, 5'd17, 5'd3, 5'd9};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the capturing edge, in_valid left high.
    task automatic send(input int idx);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = vd[idx];
        in_pc    = vpc[idx];
        in_wen   = vwen[idx];
        in_wr    = vwr[idx];
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (!flush && !reset)
                    q.push_back('{data: vd[idx], pc: vpc[idx], pc8: vp8[idx], wen: vwen[idx], wr: vwr[idx]});
                break;
            end
            waits++;
            n++;
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for vector %0d", idx);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset || flush) begin
                q.delete();
            end else begin
                if (out_wen && !out_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL wen_without_valid: out_wen=1 out_valid=0");
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: data=%h pc=%h", out_data, out_pc);
                    end else begin
                        e = q.pop_front();
                        pops++;
                        if (out_data !== e.data || out_pc !== e.pc || out_pc8 !== e.pc8 ||
                            out_wen !== e.wen || out_wr !== e.wr) begin
                            errors++;
                            $display("FAIL entry: got d=%h pc=%h pc8=%h wen=%b wr=%0d expected d=%h pc=%h pc8=%h wen=%b wr=%0d",
                                     out_data, out_pc, out_pc8, out_wen, out_wr,
                                     e.data, e.pc, e.pc8, e.wen, e.wr);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, w0;
        reset = 1'b1; flush = 1'b0; flush_pc = '0; in_valid = 1'b0;
        in_data = '0; in_pc = '0; in_wen = 1'b0; in_wr = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0000_3000);
        chk("rst_out_pc8", out_pc8, 32'h0000_3008);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_wen", {31'd0, out_wen}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back stream, one entry per cycle.
        p0 = pops; w0 = waits;
        for (int i = 0; i < 8; i++) send(i);
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("stream_pops", pops - p0, 32'd8);
        chk("stream_no_stall", waits - w0, 32'd0);
        @(posedge clk); #1;

        // Stall with input pending, then release.
        out_ready = 1'b0;
        drv_done  = 1'b0;
        fork
            begin
                send(0); send(1); send(2);
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
        join_none
        repeat (3) @(negedge clk);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_held", q.size(), HELD);
        chk("stall_out_data", out_data, vd[0]);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !drv_done; i++) @(posedge clk);
        chk("stall_drv_done", {31'd0, drv_done}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_drained", q.size(), 32'd0);

        // Flush with a write-enabled entry stalled and a new input offered.
        out_ready = 1'b0;
        send(3);
`ifdef SKID_BUFFER_EN
        send(5);
`endif
        in_valid = 1'b1; in_data = 32'hDEAD_0001; in_pc = 32'h0000_0100; in_wen = 1'b1; in_wr = 5'd7;
        flush = 1'b1; flush_pc = 32'h0000_4180; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_out_pc", out_pc, 32'h0000_4180);
        chk("flush_out_pc8", out_pc8, 32'h0000_4188);
        chk("flush_out_wen", {31'd0, out_wen}, 32'd0);
        chk("flush_out_data", out_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_flush_wen", {31'd0, out_wen}, 32'd0);
            chk("post_flush_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Reset in the middle of a transfer.
        send(6);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_pc", out_pc, 32'h0000_3000);
        chk("midrst_out_pc8", out_pc8, 32'h0000_3008);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        p0 = pops;
        send(7);
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("after_reset_pop", pops - p0, 32'd1);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
